// File: rtl/vector_div_unit.sv
// vector_div_unit: iterative restoring integer divider for one vector lane.
// Implements vdiv/vdivu/vrem/vremu at SEW 8/16/32 and retires BITS_PER_CYCLE
// quotient bits per clock.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   start_div          request a new divide (taken only while idle)
//   flush              abort the operation in flight, no completion produced
//   sew                element width 00=8, 01=16, 10/11=32
//   div_type           0=quotient, 1=remainder
//   is_signed_div      operands are two's complement
//   vs2_data/vs1_data  dividend / divisor (low SEW bits used)
//   wdata_du           registered result, held until the next completion
//   busy_du            operation in flight
//   done_du            one-cycle completion pulse
//   exception_du       one-cycle pulse with done_du on divide by zero
module vector_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start_div,
    input  logic             flush,
    input  logic [1:0]       sew,
    input  logic             div_type,
    input  logic             is_signed_div,
    input  logic [WIDTH-1:0] vs2_data,
    input  logic [WIDTH-1:0] vs1_data,
    output logic [WIDTH-1:0] wdata_du,
    output logic             busy_du,
    output logic             done_du,
    output logic             exception_du
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } state_t;

    // Mask covering the low SEW bits.
    function automatic logic [WIDTH-1:0] sew_mask(input logic [1:0] s);
        case (s)
            2'b00:   sew_mask = WIDTH'(8'hFF);
            2'b01:   sew_mask = WIDTH'(16'hFFFF);
            default: sew_mask = WIDTH'(32'hFFFF_FFFF);
        endcase
    endfunction

    // Sign bit of an SEW-wide element.
    function automatic logic sew_msb(input logic [WIDTH-1:0] x, input logic [1:0] s);
        case (s)
            2'b00:   sew_msb = x[7];
            2'b01:   sew_msb = x[15];
            default: sew_msb = x[31];
        endcase
    endfunction

    // Move an SEW-wide value to the top of the register so the next dividend
    // bit is always taken from bit WIDTH-1.
    function automatic logic [WIDTH-1:0] sew_align(input logic [WIDTH-1:0] x, input logic [1:0] s);
        case (s)
            2'b00:   sew_align = x << (WIDTH - 8);
            2'b01:   sew_align = x << (WIDTH - 16);
            default: sew_align = x << (WIDTH - 32);
        endcase
    endfunction

    // Iteration counter start value: SEW/BITS_PER_CYCLE - 1.
    function automatic logic [CNT_W-1:0] iter_init(input logic [1:0] s);
        case (s)
            2'b00:   iter_init = CNT_W'(8 / BITS_PER_CYCLE - 1);
            2'b01:   iter_init = CNT_W'(16 / BITS_PER_CYCLE - 1);
            default: iter_init = CNT_W'(32 / BITS_PER_CYCLE - 1);
        endcase
    endfunction

    // Two's complement negate within SEW bits.
    function automatic logic [WIDTH-1:0] sew_neg(input logic [WIDTH-1:0] x, input logic [1:0] s);
        sew_neg = (~x + WIDTH'(1)) & sew_mask(s);
    endfunction

    // Extend an SEW-wide value to WIDTH, signed or unsigned.
    function automatic logic [WIDTH-1:0] sew_ext(input logic [WIDTH-1:0] x, input logic [1:0] s,
                                                 input logic sgn);
        logic [WIDTH-1:0] m;
        m = sew_mask(s);
        if (sgn && sew_msb(x, s)) begin
            sew_ext = x | ~m;
        end else begin
            sew_ext = x & m;
        end
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exc_q, exc_d;
    logic [1:0]       sew_q, sew_d;
    logic             div_type_q, div_type_d;
    logic             signed_q, signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] op_a_s, op_b_s, mag_a_s, mag_b_s;
    logic             sign_a_s, sign_b_s, div_zero_s, ovf_s;
    logic [WIDTH-1:0] spec_res_s;
    logic [WIDTH:0]   trial_s, diff_s;
    logic [WIDTH-1:0] step_rem_s, step_dvd_s, step_quot_s;
    logic [WIDTH-1:0] fix_q_s, fix_r_s, fix_res_s;

    // Operand preparation and special-case detection for an incoming request.
    always_comb begin
        op_a_s     = vs2_data & sew_mask(sew);
        op_b_s     = vs1_data & sew_mask(sew);
        sign_a_s   = is_signed_div & sew_msb(op_a_s, sew);
        sign_b_s   = is_signed_div & sew_msb(op_b_s, sew);
        mag_a_s    = sign_a_s ? sew_neg(op_a_s, sew) : op_a_s;
        mag_b_s    = sign_b_s ? sew_neg(op_b_s, sew) : op_b_s;
        div_zero_s = (op_b_s == WIDTH'(0));
        // Most negative SEW value divided by -1 overflows the quotient.
        ovf_s      = is_signed_div
                   && (op_a_s == (sew_mask(sew) ^ (sew_mask(sew) >> 1)))
                   && (op_b_s == sew_mask(sew));
        if (div_zero_s) begin
            spec_res_s = sew_ext(div_type ? op_a_s : sew_mask(sew), sew, is_signed_div);
        end else begin
            spec_res_s = sew_ext(div_type ? WIDTH'(0) : op_a_s, sew, is_signed_div);
        end
    end

    // BITS_PER_CYCLE restoring steps on the SEW-bit magnitudes.
    always_comb begin
        step_rem_s  = rem_q;
        step_dvd_s  = dvd_q;
        step_quot_s = quot_q;
        trial_s     = '0;
        diff_s      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial_s = {step_rem_s, step_dvd_s[WIDTH-1]};
            diff_s  = trial_s - {1'b0, divisor_q};
            if (diff_s[WIDTH]) begin
                step_rem_s  = trial_s[WIDTH-1:0];
                step_quot_s = {step_quot_s[WIDTH-2:0], 1'b0};
            end else begin
                step_rem_s  = diff_s[WIDTH-1:0];
                step_quot_s = {step_quot_s[WIDTH-2:0], 1'b1};
            end
            step_dvd_s = {step_dvd_s[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and result selection at the end of iteration.
    always_comb begin
        fix_q_s   = q_neg_q ? sew_neg(quot_q, sew_q) : (quot_q & sew_mask(sew_q));
        fix_r_s   = r_neg_q ? sew_neg(rem_q, sew_q) : (rem_q & sew_mask(sew_q));
        fix_res_s = sew_ext(div_type_q ? fix_r_s : fix_q_s, sew_q, signed_q);
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        exc_d      = 1'b0;
        sew_d      = sew_q;
        div_type_d = div_type_q;
        signed_d   = signed_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        divisor_d  = divisor_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_div) begin
                        sew_d      = (sew == 2'b11) ? 2'b10 : sew;
                        div_type_d = div_type;
                        signed_d   = is_signed_div;
                        q_neg_d    = sign_a_s ^ sign_b_s;
                        r_neg_d    = sign_a_s;
                        divisor_d  = mag_b_s;
                        dvd_d      = sew_align(mag_a_s, sew);
                        rem_d      = '0;
                        quot_d     = '0;
                        cnt_d      = iter_init(sew);
                        if (div_zero_s || ovf_s) begin
                            state_d = IDLE;
                            wdata_d = spec_res_s;
                            done_d  = 1'b1;
                            exc_d   = div_zero_s;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ITER;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ITER: begin
                    rem_d  = step_rem_s;
                    dvd_d  = step_dvd_s;
                    quot_d = step_quot_s;
                    if (cnt_q == CNT_W'(0)) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    wdata_d = fix_res_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            sew_q      <= 2'b00;
            div_type_q <= 1'b0;
            signed_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            divisor_q  <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            sew_q      <= sew_d;
            div_type_q <= div_type_d;
            signed_q   <= signed_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            divisor_q  <= divisor_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wdata_du     = wdata_q;
    assign busy_du      = busy_q;
    assign done_du      = done_q;
    assign exception_du = exc_q;

endmodule

// File: tb/tb_vector_div_unit.sv
// tb_vector_div_unit: self-checking bench for vector_div_unit.
// Four instances (BITS_PER_CYCLE = 1, 2, 4, 8) share one stimulus stream.
// Expected results are queued per instance when a request is driven and
// compared, together with latency and busy duration, when done_du pulses.
module tb_vector_div_unit;

    localparam int NI = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start_div, flush, div_type, is_signed_div;
    logic [1:0]  sew;
    logic [31:0] vs2_data, vs1_data;
    logic [31:0] wdata [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        exc   [NI];

    always #5 CLK = ~CLK;

    vector_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
        .CLK(CLK), .nRST(nRST), .start_div(start_div), .flush(flush), .sew(sew),
        .div_type(div_type), .is_signed_div(is_signed_div), .vs2_data(vs2_data),
        .vs1_data(vs1_data), .wdata_du(wdata[0]), .busy_du(busy[0]), .done_du(done[0]),
        .exception_du(exc[0]));
    vector_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_b2 (
        .CLK(CLK), .nRST(nRST), .start_div(start_div), .flush(flush), .sew(sew),
        .div_type(div_type), .is_signed_div(is_signed_div), .vs2_data(vs2_data),
        .vs1_data(vs1_data), .wdata_du(wdata[1]), .busy_du(busy[1]), .done_du(done[1]),
        .exception_du(exc[1]));
    vector_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
        .CLK(CLK), .nRST(nRST), .start_div(start_div), .flush(flush), .sew(sew),
        .div_type(div_type), .is_signed_div(is_signed_div), .vs2_data(vs2_data),
        .vs1_data(vs1_data), .wdata_du(wdata[2]), .busy_du(busy[2]), .done_du(done[2]),
        .exception_du(exc[2]));
    vector_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(8)) u_b8 (
        .CLK(CLK), .nRST(nRST), .start_div(start_div), .flush(flush), .sew(sew),
        .div_type(div_type), .is_signed_div(is_signed_div), .vs2_data(vs2_data),
        .vs1_data(vs1_data), .wdata_du(wdata[3]), .busy_du(busy[3]), .done_du(done[3]),
        .exception_du(exc[3]));

    typedef struct {
        logic [31:0] wdata;
        logic        exc;
        int          start_cyc;
        int          lat;
        int          busy;
    } exp_t;

    typedef struct {
        logic [1:0]  sew;
        logic        dt;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    exp_t sbq [NI][$];
    int   busy_cnt [NI];
    int   cyc;
    int   n_chk;
    int   n_pass;

    function automatic int sew_bits(input logic [1:0] s);
        case (s)
            2'b00:   return 8;
            2'b01:   return 16;
            default: return 32;
        endcase
    endfunction

    // Reference model using native 64-bit signed arithmetic.
    task automatic ref_div(input logic [1:0] s, input logic dt, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ex, output logic spec);
        int     bits;
        longint m, ua, ub, sa, sb, q, r, v;
        bits = sew_bits(s);
        m    = (longint'(1) << bits) - 1;
        ua   = longint'({32'd0, a}) & m;
        ub   = longint'({32'd0, b}) & m;
        sa   = (sg && ua[bits-1]) ? ua - (longint'(1) << bits) : ua;
        sb   = (sg && ub[bits-1]) ? ub - (longint'(1) << bits) : ub;
        if (ub == 0) begin
            q = -1; r = sa; ex = 1'b1; spec = 1'b1;
        end else if (sg && sa == -(longint'(1) << (bits - 1)) && sb == -1) begin
            q = sa; r = 0; ex = 1'b0; spec = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb; ex = 1'b0; spec = 1'b0;
        end
        v   = dt ? r : q;
        res = sg ? v[31:0] : 32'(v & m);
    endtask

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst %0d: got %h required %h", name, inst, act, exp);
    endtask

    // Sample all instances and retire completions against the scoreboard.
    task automatic monitor();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (exc[i] && !done[i]) begin
                n_chk++;
                $display("FAIL exc_without_done inst %0d: got exception_du=1 required 0", i);
            end
            if (done[i]) begin
                if (sbq[i].size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_done inst %0d: got done_du=1 required 0", i);
                end else begin
                    e = sbq[i].pop_front();
                    check("wdata", i, wdata[i], e.wdata);
                    check("exception", i, 32'(exc[i]), 32'(e.exc));
                    check("latency", i, 32'(cyc - e.start_cyc), 32'(e.lat));
                    check("busy_cycles", i, 32'(busy_cnt[i]), 32'(e.busy));
                end
                busy_cnt[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        monitor();
    endtask

    // Present a request and queue its expectation for instances >= first_inst.
    task automatic launch(input logic [1:0] s, input logic dt, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ew, input logic ee, input int first_inst);
        logic [31:0] mres;
        logic        mex, spec;
        exp_t        e;
        sew = s; div_type = dt; is_signed_div = sg; vs2_data = a; vs1_data = b;
        start_div = 1'b1;
        ref_div(s, dt, sg, a, b, mres, mex, spec);
        for (int i = first_inst; i < NI; i++) begin
            e.wdata     = ew;
            e.exc       = ee;
            e.start_cyc = cyc;
            e.lat       = spec ? 1 : sew_bits(s) / (1 << i) + 2;
            e.busy      = spec ? 0 : sew_bits(s) / (1 << i) + 1;
            sbq[i].push_back(e);
        end
    endtask

    task automatic clear_busy();
        for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
    endtask

    task automatic wait_drain(input int budget);
        int  k;
        bit  pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < budget) begin
            pending = 1'b0;
            for (int i = 0; i < NI; i++) if (sbq[i].size() != 0) pending = 1'b1;
            if (pending) begin
                tick();
                k++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (sbq[i].size() != 0) begin
                n_chk++;
                $display("FAIL timeout inst %0d: got %0d pending results required 0", i, sbq[i].size());
                sbq[i].delete();
            end
        end
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NI; i++) begin
            check({name, "_wdata"}, i, wdata[i], 32'h0);
            check({name, "_busy"}, i, 32'(busy[i]), 32'h0);
            check({name, "_done"}, i, 32'(done[i]), 32'h0);
            check({name, "_exc"}, i, 32'(exc[i]), 32'h0);
        end
    endtask

    vec_t tbl [15];

    initial begin
        logic [31:0] r_res;
        logic        r_ex, r_spec;
        logic [1:0]  rs;
        logic [31:0] ra, rb;
        logic        rdt, rsg;

        tbl[0]  = '{2'b00, 1'b0, 1'b1, 32'h0000_00F9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        tbl[1]  = '{2'b00, 1'b1, 1'b1, 32'h0000_00F9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 32'd100,       32'd7,         32'h0000_000E, 1'b0};
        tbl[3]  = '{2'b10, 1'b1, 1'b0, 32'd100,       32'd7,         32'h0000_0002, 1'b0};
        tbl[4]  = '{2'b01, 1'b0, 1'b0, 32'hABCD_1234, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1};
        tbl[5]  = '{2'b01, 1'b1, 1'b0, 32'hABCD_1234, 32'hFFFF_0000, 32'h0000_1234, 1'b1};
        tbl[6]  = '{2'b01, 1'b0, 1'b1, 32'hABCD_1234, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1};
        tbl[7]  = '{2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        tbl[8]  = '{2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[9]  = '{2'b11, 1'b0, 1'b0, 32'd200,       32'd3,         32'h0000_0042, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 32'h1234_5680, 32'hABCD_EFFF, 32'hFFFF_FF80, 1'b0};
        tbl[11] = '{2'b01, 1'b1, 1'b1, 32'hFFFF_8001, 32'h0000_0010, 32'hFFFF_FFF1, 1'b0};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_00FF, 1'b0};
        tbl[13] = '{2'b10, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
        tbl[14] = '{2'b01, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0100, 32'h0000_00FF, 1'b0};

        n_chk = 0; n_pass = 0; cyc = 0;
        nRST = 1'b0; start_div = 1'b0; flush = 1'b0; sew = 2'b00;
        div_type = 1'b0; is_signed_div = 1'b0; vs2_data = '0; vs1_data = '0;
        clear_busy();
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        nRST = 1'b1;
        tick();

        // Directed vectors.
        for (int v = 0; v < 15; v++) begin
            clear_busy();
            launch(tbl[v].sew, tbl[v].dt, tbl[v].sg, tbl[v].a, tbl[v].b, tbl[v].res, tbl[v].exc, 0);
            tick();
            start_div = 1'b0;
            wait_drain(60);
        end

        // Back-to-back: special case completes, new request accepted while done is high.
        clear_busy();
        launch(2'b00, 1'b0, 1'b0, 32'h0000_0037, 32'h0000_0000, 32'h0000_00FF, 1'b1, 0);
        tick();
        launch(2'b00, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 0);
        tick();
        start_div = 1'b0;
        wait_drain(60);

        // start_div while busy is ignored.
        clear_busy();
        launch(2'b10, 1'b0, 1'b0, 32'd200, 32'd3, 32'h0000_0042, 1'b0, 0);
        tick();
        start_div = 1'b0;
        repeat (4) tick();
        sew = 2'b00; vs2_data = 32'd5; vs1_data = 32'd1; div_type = 1'b1; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        wait_drain(60);

        // Flush mid-operation: the two fast instances finish before the flush.
        clear_busy();
        launch(2'b10, 1'b0, 1'b0, 32'd1000, 32'd3, 32'h0000_014D, 1'b0, 2);
        tick();
        start_div = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        check("busy_before_flush", 0, 32'(busy[0]), 32'h1);
        tick();
        flush = 1'b0;
        check("flush_busy", 0, 32'(busy[0]), 32'h0);
        check("flush_busy", 1, 32'(busy[1]), 32'h0);
        check("flush_wdata_kept", 0, wdata[0], 32'h0000_0042);
        check("flush_wdata_kept", 1, wdata[1], 32'h0000_0042);
        check("flush_wdata_done", 2, wdata[2], 32'h0000_014D);
        repeat (40) tick();

        // Flush overrides a simultaneous start.
        sew = 2'b10; div_type = 1'b0; is_signed_div = 1'b0;
        vs2_data = 32'd100; vs1_data = 32'd7; start_div = 1'b1; flush = 1'b1;
        tick();
        start_div = 1'b0; flush = 1'b0;
        for (int i = 0; i < NI; i++) check("flush_start_busy", i, 32'(busy[i]), 32'h0);
        repeat (40) tick();

        // Asynchronous reset in the middle of iteration.
        launch(2'b10, 1'b0, 1'b0, 32'd1000, 32'd3, 32'h0, 1'b0, NI);
        tick();
        start_div = 1'b0;
        repeat (4) tick();
        nRST = 1'b0;
        #1;
        check_all_zero("reset_mid_iter");
        tick();
        nRST = 1'b1;
        repeat (3) tick();

        // Random operands at every SEW against the reference model.
        for (int n = 0; n < 48; n++) begin
            rs  = 2'($urandom_range(0, 3));
            rdt = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom();
            rb  = $urandom();
            if ($urandom_range(0, 7) == 0) rb = rb & 32'hFFFF_0000;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_000F;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0080;
                rb = 32'hFFFF_FFFF;
            end
            ref_div(rs, rdt, rsg, ra, rb, r_res, r_ex, r_spec);
            clear_busy();
            launch(rs, rdt, rsg, ra, rb, r_res, r_ex, 0);
            tick();
            start_div = 1'b0;
            wait_drain(60);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
